// File: rtl/lu_matmul_sequencer.sv
// rtl/lu_matmul_sequencer.sv - fetches A rows / B columns, issues one dot product per (i,j), collects C rows
module lu_matmul_sequencer #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        start,
    output logic                        in_ready_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [$clog2(SIZE)-1:0]     a_row_addr_o,
    output logic                        a_row_addr_valid_o,
    input  logic [SIZE*2*WIDTH-1:0]     a_row_i,
    input  logic                        a_row_valid_i,
    output logic [$clog2(SIZE)-1:0]     b_col_addr_o,
    output logic                        b_col_addr_valid_o,
    input  logic [SIZE*2*WIDTH-1:0]     b_col_i,
    input  logic                        b_col_valid_i,
    output logic [SIZE*4*WIDTH-1:0]     mul_operands_o,
    output logic                        mul_in_valid_o,
    input  logic                        mul_in_ready_i,
    input  logic [2*WIDTH-1:0]          mul_result_i,
    input  logic                        mul_out_valid_i,
    output logic                        mul_out_ready_o,
    output logic [SIZE*2*WIDTH-1:0]     c_row_o,
    output logic [$clog2(SIZE)-1:0]     c_row_addr_o,
    output logic                        c_row_valid_o,
    input  logic                        c_row_out_ready_i
);
    localparam int AW = $clog2(SIZE);
    localparam int EW = 2 * WIDTH;
    localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t              r_state;
    state_t              r_prev_state;
    state_t              w_next_state;
    logic [AW-1:0]       r_i;
    logic [AW-1:0]       r_j;
    logic [AW-1:0]       r_ri;
    logic [AW-1:0]       r_rj;
    logic [AW-1:0]       r_c_addr;
    logic [SIZE*EW-1:0]  r_a_buf;
    logic [SIZE*EW-1:0]  r_b_buf;
    logic [SIZE*EW-1:0]  r_c_buf;
    logic                r_c_valid;
    logic                r_discard;
    logic                r_done;
    logic                w_res_take;
    logic                w_crow_hs;
    logic                w_last_row_hs;

    // Results are dropped while idle or inside the post-flush discard window.
    assign w_res_take    = mul_out_valid_i && mul_out_ready_o && !r_discard
                           && (r_state != S_IDLE) && !flush_i;
    assign w_crow_hs     = r_c_valid && c_row_out_ready_i;
    assign w_last_row_hs = w_crow_hs && (r_c_addr == LAST);

    always_comb begin
        w_next_state = r_state;
        if (flush_i) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (start) w_next_state = S_FETCH_A;
                S_FETCH_A: if (a_row_valid_i) w_next_state = S_FETCH_B;
                S_FETCH_B: if (b_col_valid_i) w_next_state = S_ISSUE;
                S_ISSUE: begin
                    if (mul_in_ready_i) begin
                        if (r_j != LAST)      w_next_state = S_FETCH_B;
                        else if (r_i != LAST) w_next_state = S_FETCH_A;
                        else                  w_next_state = S_DRAIN;
                    end
                end
                S_DRAIN:   if (w_last_row_hs) w_next_state = S_IDLE;
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_prev_state <= S_IDLE;
            r_i          <= '0;
            r_j          <= '0;
            r_a_buf      <= '0;
            r_b_buf      <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_prev_state <= r_state;
            r_done       <= (r_state == S_DRAIN) && w_last_row_hs && !flush_i;
            if (flush_i) begin
                r_i <= '0;
                r_j <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_i <= '0;
                            r_j <= '0;
                        end
                    end
                    S_FETCH_A: if (a_row_valid_i) r_a_buf <= a_row_i;
                    S_FETCH_B: if (b_col_valid_i) r_b_buf <= b_col_i;
                    S_ISSUE: begin
                        if (mul_in_ready_i) begin
                            if (r_j != LAST) begin
                                r_j <= r_j + 1'b1;
                            end else if (r_i != LAST) begin
                                r_i <= r_i + 1'b1;
                                r_j <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rj      <= '0;
            r_ri      <= '0;
            r_c_addr  <= '0;
            r_c_buf   <= '0;
            r_c_valid <= 1'b0;
            r_discard <= 1'b0;
        end else if (flush_i) begin
            r_rj      <= '0;
            r_ri      <= '0;
            r_c_valid <= 1'b0;
            r_discard <= 1'b1;
        end else begin
            if (r_discard && !mul_out_valid_i) begin
                r_discard <= 1'b0;
            end
            if ((r_state == S_IDLE) && start) begin
                r_rj <= '0;
                r_ri <= '0;
            end
            if (w_crow_hs) begin
                r_c_valid <= 1'b0;
            end
            // Never coincides with w_crow_hs: results are only taken while no row is pending.
            if (w_res_take) begin
                r_c_buf[r_rj*EW +: EW] <= mul_result_i;
                if (r_rj == LAST) begin
                    r_rj      <= '0;
                    r_c_valid <= 1'b1;
                    r_c_addr  <= r_ri;
                    r_ri      <= (r_ri == LAST) ? '0 : r_ri + 1'b1;
                end else begin
                    r_rj <= r_rj + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < SIZE; k++) begin : g_pack
        assign mul_operands_o[(4*k+0)*WIDTH +: WIDTH] = r_a_buf[k*EW +: WIDTH];
        assign mul_operands_o[(4*k+1)*WIDTH +: WIDTH] = r_a_buf[k*EW+WIDTH +: WIDTH];
        assign mul_operands_o[(4*k+2)*WIDTH +: WIDTH] = r_b_buf[k*EW +: WIDTH];
        assign mul_operands_o[(4*k+3)*WIDTH +: WIDTH] = r_b_buf[k*EW+WIDTH +: WIDTH];
    end

    assign in_ready_o         = (r_state == S_IDLE);
    assign busy_o             = (r_state != S_IDLE);
    assign done_o             = r_done;
    assign a_row_addr_o       = r_i;
    assign b_col_addr_o       = r_j;
    assign a_row_addr_valid_o = (r_state == S_FETCH_A) && (r_prev_state != S_FETCH_A);
    assign b_col_addr_valid_o = (r_state == S_FETCH_B) && (r_prev_state != S_FETCH_B);
    assign mul_in_valid_o     = (r_state == S_ISSUE);
    assign mul_out_ready_o    = !r_c_valid;
    assign c_row_o            = r_c_buf;
    assign c_row_addr_o       = r_c_addr;
    assign c_row_valid_o      = r_c_valid;

endmodule

// File: tb/tb_lu_matmul_sequencer.sv
// tb/tb_lu_matmul_sequencer.sv - table-driven and randomized checks of lu_matmul_sequencer against a matrix model
module tb_lu_matmul_sequencer;
    localparam int SIZE  = 4;
    localparam int WIDTH = 64;
    localparam int AW    = 2;
    localparam int EW    = 2 * WIDTH;

    logic clk = 1'b0;
    logic rst_ni, flush_i, start;
    logic in_ready_o, busy_o, done_o;
    logic [AW-1:0] a_row_addr_o, b_col_addr_o, c_row_addr_o;
    logic a_row_addr_valid_o, b_col_addr_valid_o;
    logic [SIZE*EW-1:0] a_row_i, b_col_i, c_row_o;
    logic a_row_valid_i, b_col_valid_i;
    logic [SIZE*4*WIDTH-1:0] mul_operands_o;
    logic mul_in_valid_o, mul_in_ready_i, mul_out_valid_i, mul_out_ready_o;
    logic [EW-1:0] mul_result_i;
    logic c_row_valid_o, c_row_out_ready_i;

    lu_matmul_sequencer #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .start(start),
        .in_ready_o(in_ready_o), .busy_o(busy_o), .done_o(done_o),
        .a_row_addr_o(a_row_addr_o), .a_row_addr_valid_o(a_row_addr_valid_o),
        .a_row_i(a_row_i), .a_row_valid_i(a_row_valid_i),
        .b_col_addr_o(b_col_addr_o), .b_col_addr_valid_o(b_col_addr_valid_o),
        .b_col_i(b_col_i), .b_col_valid_i(b_col_valid_i),
        .mul_operands_o(mul_operands_o), .mul_in_valid_o(mul_in_valid_o),
        .mul_in_ready_i(mul_in_ready_i), .mul_result_i(mul_result_i),
        .mul_out_valid_i(mul_out_valid_i), .mul_out_ready_o(mul_out_ready_o),
        .c_row_o(c_row_o), .c_row_addr_o(c_row_addr_o), .c_row_valid_o(c_row_valid_o),
        .c_row_out_ready_i(c_row_out_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int amode;     // 0 random, 1 identity, 2 all (1+j1)
        int bmode;     // 0 random, 1 (k+1)+j(k+2), 2 all (2+j0)
        int mem_lat;
        int mlat;
        int rdy_pct;
        int sink_pct;
        int hold;
        int poke;
        int exp_rows;
        int exp_a;
        int exp_b;
        int exp_done;
    } vec_t;

    typedef struct {
        logic [EW-1:0] val;
        int            due;
    } mres_t;

    real am_re[SIZE][SIZE], am_im[SIZE][SIZE];
    real bm_re[SIZE][SIZE], bm_im[SIZE][SIZE];
    real cr_re[SIZE][SIZE], cr_im[SIZE][SIZE];
    mres_t mq[$];
    int total = 0, bad = 0;
    int cyc = 0;
    int mem_lat = 1, mlat = 1, rdy_pct = 100, sink_pct = 100, hold = 0;
    int a_cnt = 0, b_cnt = 0, a_addr = 0, b_addr = 0;
    int a_req = 0, b_req = 0, issued = 0, rows_acc = 0, done_cnt = 0;
    logic hold_started = 1'b0;
    logic [SIZE*EW-1:0] snap_row;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_real(input string name, input real act, input real exp);
        real mag, tol, d;
        mag = (exp < 0.0) ? -exp : exp;
        tol = 1e-9 * ((mag > 1.0) ? mag : 1.0);
        d = act - exp;
        if (d < 0.0) d = -d;
        total++;
        if (d > tol) begin
            bad++;
            $display("FAIL %s: got %g expected %g", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input real re, input real im);
        return {$realtobits(im), $realtobits(re)};
    endfunction

    function automatic logic [SIZE*EW-1:0] junk();
        logic [SIZE*EW-1:0] r;
        for (int w = 0; w < SIZE*EW/32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic real rnd10();
        return real'(int'($urandom_range(0, 2000)) - 1000) / 100.0;
    endfunction

    task automatic set_matrices(input int amode, input int bmode);
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                case (amode)
                    1:       begin am_re[r][c] = (r == c) ? 1.0 : 0.0; am_im[r][c] = 0.0; end
                    2:       begin am_re[r][c] = 1.0; am_im[r][c] = 1.0; end
                    default: begin am_re[r][c] = rnd10(); am_im[r][c] = rnd10(); end
                endcase
                case (bmode)
                    1:       begin bm_re[r][c] = real'(r + 1); bm_im[r][c] = real'(r + 2); end
                    2:       begin bm_re[r][c] = 2.0; bm_im[r][c] = 0.0; end
                    default: begin bm_re[r][c] = rnd10(); bm_im[r][c] = rnd10(); end
                endcase
            end
        end
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                cr_re[r][c] = 0.0;
                cr_im[r][c] = 0.0;
                for (int k = 0; k < SIZE; k++) begin
                    cr_re[r][c] += am_re[r][k] * bm_re[k][c] - am_im[r][k] * bm_im[k][c];
                    cr_im[r][c] += am_re[r][k] * bm_im[k][c] + am_im[r][k] * bm_re[k][c];
                end
            end
        end
    endtask

    // One clock of the memories, the multiplier and the C-row sink, evaluated at the falling edge.
    task automatic tick();
        real sre, sim, ar, ai, br, bi;
        @(negedge clk);
        cyc++;
        if (!rst_ni) begin
            mq.delete();
            a_cnt = 0; b_cnt = 0;
            a_row_valid_i = 1'b0; b_col_valid_i = 1'b0;
            mul_out_valid_i = 1'b0; mul_in_ready_i = 1'b0; c_row_out_ready_i = 1'b0;
            return;
        end
        a_row_valid_i = 1'b0;
        a_row_i = junk();
        if (a_cnt > 0) begin
            a_cnt--;
            if (a_cnt == 0) begin
                a_row_valid_i = 1'b1;
                for (int k = 0; k < SIZE; k++) a_row_i[k*EW +: EW] = pack(am_re[a_addr][k], am_im[a_addr][k]);
            end
        end
        if (a_row_addr_valid_o) begin a_req++; a_addr = int'(a_row_addr_o); a_cnt = mem_lat; end
        b_col_valid_i = 1'b0;
        b_col_i = junk();
        if (b_cnt > 0) begin
            b_cnt--;
            if (b_cnt == 0) begin
                b_col_valid_i = 1'b1;
                for (int k = 0; k < SIZE; k++) b_col_i[k*EW +: EW] = pack(bm_re[k][b_addr], bm_im[k][b_addr]);
            end
        end
        if (b_col_addr_valid_o) begin b_req++; b_addr = int'(b_col_addr_o); b_cnt = mem_lat; end

        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mul_out_valid_i = 1'b1;
            mul_result_i = mq[0].val;
        end else begin
            mul_out_valid_i = 1'b0;
            mul_result_i = {$urandom, $urandom, $urandom, $urandom};
        end
        if (mul_out_valid_i && mul_out_ready_o) void'(mq.pop_front());
        mul_in_ready_i = (int'($urandom_range(1, 100)) <= rdy_pct);
        if (mul_in_valid_o && mul_in_ready_i) begin
            sre = 0.0; sim = 0.0;
            for (int k = 0; k < SIZE; k++) begin
                ar = $bitstoreal(mul_operands_o[(4*k+0)*WIDTH +: WIDTH]);
                ai = $bitstoreal(mul_operands_o[(4*k+1)*WIDTH +: WIDTH]);
                br = $bitstoreal(mul_operands_o[(4*k+2)*WIDTH +: WIDTH]);
                bi = $bitstoreal(mul_operands_o[(4*k+3)*WIDTH +: WIDTH]);
                sre += ar * br - ai * bi;
                sim += ar * bi + ai * br;
            end
            mq.push_back('{pack(sre, sim), cyc + mlat});
            issued++;
        end

        if (hold > 0 && c_row_valid_o) begin
            c_row_out_ready_i = 1'b0;
            if (!hold_started) begin
                hold_started = 1'b1;
                snap_row = c_row_o;
            end
            check("hold_mul_out_ready", 64'(mul_out_ready_o), 64'd0);
            check("hold_row_stable", 64'(c_row_o == snap_row), 64'd1);
            hold--;
        end else begin
            c_row_out_ready_i = (int'($urandom_range(1, 100)) <= sink_pct);
        end
        if (c_row_valid_o && c_row_out_ready_i) begin
            check("c_row_addr", 64'(c_row_addr_o), 64'(rows_acc));
            for (int j = 0; j < SIZE; j++) begin
                check_real($sformatf("c[%0d][%0d].re", c_row_addr_o, j),
                           $bitstoreal(c_row_o[j*EW +: WIDTH]), cr_re[c_row_addr_o][j]);
                check_real($sformatf("c[%0d][%0d].im", c_row_addr_o, j),
                           $bitstoreal(c_row_o[j*EW+WIDTH +: WIDTH]), cr_im[c_row_addr_o][j]);
            end
            rows_acc++;
        end
        if (done_o) done_cnt++;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl"}, 64'({in_ready_o, busy_o, done_o, a_row_addr_valid_o, b_col_addr_valid_o,
                                   mul_in_valid_o, mul_out_ready_o, c_row_valid_o}), 64'b1000_0010);
        check({tag, "_addrs"}, 64'({a_row_addr_o, b_col_addr_o, c_row_addr_o}), 64'd0);
        check({tag, "_data"}, 64'({|c_row_o, |mul_operands_o}), 64'd0);
    endtask

    task automatic clear_counts();
        a_req = 0; b_req = 0; issued = 0; rows_acc = 0; done_cnt = 0;
        hold_started = 1'b0;
    endtask

    task automatic run_product(input vec_t v, input string tag);
        int n;
        set_matrices(v.amode, v.bmode);
        mem_lat = v.mem_lat; mlat = v.mlat; rdy_pct = v.rdy_pct; sink_pct = v.sink_pct; hold = v.hold;
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 5000) begin
            if (v.poke != 0 && n == 30) begin
                check({tag, "_busy_at_poke"}, 64'(busy_o), 64'd1);
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            n++;
        end
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL %s_timeout: got no done_o expected one pulse", tag);
        end
        repeat (4) tick();
        check({tag, "_rows"}, 64'(rows_acc), 64'(v.exp_rows));
        check({tag, "_a_reqs"}, 64'(a_req), 64'(v.exp_a));
        check({tag, "_b_reqs"}, 64'(b_req), 64'(v.exp_b));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'(v.exp_done));
        check({tag, "_idle_after"}, 64'({busy_o, in_ready_o}), 64'b01);
    endtask

    vec_t vecs[6];

    initial begin
        int n, snap;
        rst_ni = 1'b0; flush_i = 1'b0; start = 1'b0;
        a_row_i = '0; b_col_i = '0; a_row_valid_i = 1'b0; b_col_valid_i = 1'b0;
        mul_in_ready_i = 1'b0; mul_result_i = '0; mul_out_valid_i = 1'b0; c_row_out_ready_i = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
        rst_ni = 1'b1;
        tick();

        vecs[0] = '{1, 1, 2, 5, 100, 100,  0, 0, 4, 4, 16, 1};
        vecs[1] = '{2, 2, 1, 3, 100, 100,  0, 0, 4, 4, 16, 1};
        vecs[2] = '{0, 0, 3, 5,  60, 100,  0, 0, 4, 4, 16, 1};
        vecs[3] = '{0, 0, 1, 1, 100,  70, 20, 0, 4, 4, 16, 1};
        vecs[4] = '{0, 0, 4, 2,  40,  50,  0, 0, 4, 4, 16, 1};
        vecs[5] = '{0, 0, 2, 4,  80, 100,  0, 1, 4, 4, 16, 1};
        for (int t = 0; t < 6; t++) run_product(vecs[t], $sformatf("vec%0d", t));

        // flush while issuing (i=2, j=1)
        set_matrices(0, 0);
        mem_lat = 2; mlat = 5; rdy_pct = 50; sink_pct = 100; hold = 0;
        clear_counts();
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!(mul_in_valid_o && a_row_addr_o == 2'd2 && b_col_addr_o == 2'd1) && n < 2000) begin
            tick(); n++;
        end
        check("flush_reached_issue_2_1", 64'(n < 2000), 64'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_idle", 64'({busy_o, in_ready_o, mul_in_valid_o, c_row_valid_o}), 64'b0100);
        snap = rows_acc;
        repeat (30) tick();
        check("flush_no_more_rows", 64'(rows_acc), 64'(snap));
        check("flush_no_done", 64'(done_cnt), 64'd0);
        run_product(vecs[2], "after_flush");

        // asynchronous reset while draining
        set_matrices(0, 0);
        mem_lat = 1; mlat = 5; rdy_pct = 100; sink_pct = 100; hold = 0;
        clear_counts();
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (issued < SIZE*SIZE && n < 2000) begin
            tick(); n++;
        end
        check("drain_reached", 64'(issued), 64'(SIZE*SIZE));
        tick();
        check("drain_busy", 64'(busy_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check_reset_vals("rst_drain");
        tick(); tick();
        rst_ni = 1'b1;
        snap = rows_acc;
        repeat (20) tick();
        check("rst_no_more_rows", 64'(rows_acc), 64'(snap));
        check("rst_no_done", 64'(done_cnt), 64'd0);
        run_product(vecs[0], "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lu_matmul_sequencer.md
Name: lu_matmul_sequencer

Overview:
- Sequences the shared complex_matrix_mul datapath to compute C = A·B for SIZE×SIZE complex double matrices.
- Fetches A rows and B columns from external row memories, assembles operand vectors, and issues one dot-product per (i,j).
- Collects in-order results into a C row buffer and emits completed rows with a valid/ready handshake.
- Replaces hand-driven bench loops around the LU and triangular-inverse flow; sits between the row memories and complex_matrix_mul.

Parameters:
- SIZE, 4, matrix dimension; power of two, at least 2.
- WIDTH, 64, bits per real or imaginary IEEE-754 double component.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous abort to IDLE
- start  in  1  begin a product; sampled only in IDLE
- in_ready_o  out  1  high in IDLE
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse when the last C row is accepted
- a_row_addr_o  out  $clog2(SIZE)  A row read address
- a_row_addr_valid_o  out  1  A read request, one-cycle pulse
- a_row_i  in  SIZE*2*WIDTH  A row; element k at [k*2W +: 2W] = {im,re}
- a_row_valid_i  in  1  A row data valid
- b_col_addr_o  out  $clog2(SIZE)  B column read address; B is stored column-major
- b_col_addr_valid_o  out  1  B read request, one-cycle pulse
- b_col_i  in  SIZE*2*WIDTH  B column, same element packing as a_row_i
- b_col_valid_i  in  1  B column data valid
- mul_operands_o  out  SIZE*4*WIDTH  operand k at words 4k..4k+3 = {a_re, a_im, b_re, b_im}
- mul_in_valid_o  out  1  operand vector valid
- mul_in_ready_i  in  1  multiplier accepts the vector
- mul_result_i  in  2*WIDTH  dot-product result {im,re}
- mul_out_valid_i  in  1  result valid
- mul_out_ready_o  out  1  controller accepts the result
- c_row_o  out  SIZE*2*WIDTH  completed C row
- c_row_addr_o  out  $clog2(SIZE)  C row index
- c_row_valid_o  out  1  C row valid
- c_row_out_ready_i  in  1  downstream accepts the C row

Behaviour:
- Reset: all outputs 0 except in_ready_o=1 and mul_out_ready_o=1; FSM in IDLE; counters i, j, ri, rj = 0; buffers cleared.

Issue FSM:
- IDLE: on start, set i=0, j=0 and go to FETCH_A. A start outside IDLE is ignored.
- FETCH_A: on the entry cycle, pulse a_row_addr_valid_o with a_row_addr_o=i. Hold until a_row_valid_i, latch a_row_i into the A buffer, go to FETCH_B.
- FETCH_B: on the entry cycle, pulse b_col_addr_valid_o with b_col_addr_o=j. Hold until b_col_valid_i, latch the column, go to ISSUE.
- ISSUE: hold mul_in_valid_o=1 with operands stable until mul_in_ready_i. On the handshake:
  - if j<SIZE-1: j++, go to FETCH_B;
  - else if i<SIZE-1: i++, j=0, go to FETCH_A;
  - else go to DRAIN.
- DRAIN: wait until SIZE² results have been received and the last C row has been accepted. Then pulse done_o and go to IDLE.
- Memory latency is arbitrary (at least 1 cycle). Data arriving outside the matching FETCH state is ignored.

Result path (concurrent with the issue FSM):
- mul_out_ready_o = !c_row_valid_o.
- On a result handshake: cbuf[rj] = mul_result_i, then rj++.
- When rj wraps from SIZE-1 to 0: assert c_row_valid_o with c_row_addr_o=ri on the next cycle, then ri++.
- c_row_o, c_row_addr_o and c_row_valid_o stay stable until c_row_out_ready_i. The valid drops the cycle after the handshake.
- Results are assumed in issue order. The multiplier pipeline bounds outstanding operations; back-pressure propagates through mul_out_ready_o.
- A result and a C-row handshake never occur in the same cycle (ready is gated), so no buffer is overwritten before acceptance.

Operand packing:
- word 4k = A[i][k].re, 4k+1 = A[i][k].im, 4k+2 = B[k][j].re, 4k+3 = B[k][j].im.
- B[k][j] is element k of column j.

Flush:
- flush_i in any state returns to IDLE next cycle, clears counters, and drops all valids.
- Results arriving after a flush are accepted and discarded until mul_out_valid_i has been low for 1 cycle.

Boundaries:
- A counter write and a wrap happen in the same cycle with no lost element.
- An asynchronous reset mid-operation returns immediately to the reset values.
- The address counters wrap only via FSM transitions, never at the top of the counter range.

Test Plan:
- A = I, B with entries (k+1)+j(k+2) -> C equals B exactly; 16 results; 4 rows at addresses 0..3 in order; one done_o pulse.
- A all (1+j1), B all (2+j0), memory latency 1 -> every C element (8+j8).
- Random A, B (values in ±10.00), memory latency 3 cycles, multiplier latency 5, random mul_in_ready_i -> C matches a real-valued model within 1e-9 relative error; a_row_addr_valid_o fires exactly 4 times and b_col_addr_valid_o 16 times.
- c_row_out_ready_i held low for 20 cycles after the first row -> mul_out_ready_o=0, no cbuf change, c_row_o stable; completes correctly after release.
- flush_i asserted in ISSUE at i=2, j=1 -> IDLE next cycle, busy_o=0, no further C rows; a new start computes a full product correctly.
- start pulsed while busy, and rst_ni low mid-DRAIN -> no effect on the first; all outputs at reset values immediately on the second.
